// File: rtl/dsp48a1_op_sequencer.sv
// dsp48a1_op_sequencer
// Command-side master for a fully registered DSP48A1 slice. Accepted
// operations are registered onto the slice ports, tracked through the
// slice pipeline by a one-hot-per-stage valid shift register, and the
// slice P/CARRYOUT is captured into a first-word-fall-through result FIFO
// exactly LATENCY+1 edges after acceptance. Issue is credit limited so
// every capture always finds a free FIFO slot.
module dsp48a1_op_sequencer #(
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [17:0] cmd_a,
    input  logic [17:0] cmd_b,
    input  logic [17:0] cmd_d,
    input  logic [47:0] cmd_c,
    input  logic [7:0]  cmd_opmode,
    input  logic        cmd_carryin,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [47:0] rsp_p,
    output logic        rsp_carryout,
    input  logic        flush,
    output logic [17:0] dsp_a,
    output logic [17:0] dsp_b,
    output logic [17:0] dsp_d,
    output logic [47:0] dsp_c,
    output logic [7:0]  dsp_opmode,
    output logic        dsp_carryin,
    output logic        dsp_ce,
    output logic        dsp_rst,
    input  logic [47:0] dsp_p,
    input  logic        dsp_carryout,
    output logic [3:0]  inflight,
    output logic [3:0]  fifo_level
);

    localparam int         PW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [3:0] CNT_LOAD    = 4'(LATENCY + 1);
    localparam logic [4:0] DEPTH_W     = 5'(FIFO_DEPTH);
    // Bubble keeps only the Z-mux select of the last op: X=0, no pre-adder,
    // no carry, add. With Z=P this makes the slice hold P.
    localparam logic [7:0] BUBBLE_MASK = 8'b0000_1100;

    typedef enum logic [0:0] {
        ST_FLUSH = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Sequencer state
    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        dsp_rst_q, dsp_rst_d;
    logic        dsp_ce_q, dsp_ce_d;
    logic        cmd_ready_q, cmd_ready_d;

    // Issue registers toward the slice
    logic [17:0] dsp_a_q, dsp_a_d;
    logic [17:0] dsp_b_q, dsp_b_d;
    logic [17:0] dsp_d_q, dsp_d_d;
    logic [47:0] dsp_c_q, dsp_c_d;
    logic [7:0]  dsp_opmode_q, dsp_opmode_d;
    logic        dsp_carryin_q, dsp_carryin_d;
    logic [7:0]  last_opmode_q, last_opmode_d;
    logic [LATENCY:0] vpipe_q, vpipe_d;

    // Occupancy counters and FIFO
    logic [3:0]    inflight_q, inflight_d;
    logic [3:0]    level_q, level_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [47:0]   mem_p_q  [0:FIFO_DEPTH-1];
    logic          mem_co_q [0:FIFO_DEPTH-1];
    logic          rsp_valid_q, rsp_valid_d;
    logic [47:0]   rsp_p_q, rsp_p_d;
    logic          rsp_co_q, rsp_co_d;

    // Handshake events for this edge
    logic accept_s;
    logic capture_s;
    logic pop_s;

    // Handshake events; flush takes priority over all of them
    always_comb begin
        accept_s  = cmd_valid && cmd_ready_q && !flush;
        capture_s = vpipe_q[LATENCY] && !flush;
        pop_s     = rsp_valid_q && rsp_ready && !flush;
    end

    // FSM next state: FLUSH holds the slice in reset for LATENCY+1 cycles
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dsp_rst_d = dsp_rst_q;
        dsp_ce_d  = 1'b1;
        if (flush) begin
            state_d   = ST_FLUSH;
            cnt_d     = CNT_LOAD;
            dsp_rst_d = 1'b1;
        end else begin
            case (state_q)
                ST_FLUSH: begin
                    if (cnt_q <= 4'd1) begin
                        state_d   = ST_RUN;
                        cnt_d     = 4'd0;
                        dsp_rst_d = 1'b0;
                    end else begin
                        cnt_d     = cnt_q - 4'd1;
                        dsp_rst_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    cnt_d     = 4'd0;
                    dsp_rst_d = 1'b0;
                end
                default: begin
                    state_d   = ST_FLUSH;
                    cnt_d     = CNT_LOAD;
                    dsp_rst_d = 1'b1;
                end
            endcase
        end
    end

    // Credit rule: accept only while every issued op has a FIFO slot reserved
    always_comb begin
        cmd_ready_d = (state_d == ST_RUN) &&
                      (({1'b0, inflight_d} + {1'b0, level_d}) < DEPTH_W);
    end

    // Issue path: load the command on accept, otherwise drive a hold bubble
    always_comb begin
        dsp_a_d       = 18'd0;
        dsp_b_d       = 18'd0;
        dsp_d_d       = 18'd0;
        dsp_c_d       = 48'd0;
        dsp_carryin_d = 1'b0;
        dsp_opmode_d  = last_opmode_q & BUBBLE_MASK;
        last_opmode_d = last_opmode_q;
        vpipe_d       = {vpipe_q[LATENCY-1:0], accept_s};
        if (flush) begin
            dsp_opmode_d  = 8'h00;
            last_opmode_d = 8'h00;
            vpipe_d       = '0;
        end else if (accept_s) begin
            dsp_a_d       = cmd_a;
            dsp_b_d       = cmd_b;
            dsp_d_d       = cmd_d;
            dsp_c_d       = cmd_c;
            dsp_carryin_d = cmd_carryin;
            dsp_opmode_d  = cmd_opmode;
            last_opmode_d = cmd_opmode;
        end else begin
            last_opmode_d = last_opmode_q;
        end
    end

    // Occupancy counters and FIFO pointers
    always_comb begin
        inflight_d = inflight_q;
        level_d    = level_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (flush) begin
            inflight_d = 4'd0;
            level_d    = 4'd0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            case ({accept_s, capture_s})
                2'b10:   inflight_d = inflight_q + 4'd1;
                2'b01:   inflight_d = inflight_q - 4'd1;
                default: inflight_d = inflight_q;
            endcase
            case ({capture_s, pop_s})
                2'b10:   level_d = level_q + 4'd1;
                2'b01:   level_d = level_q - 4'd1;
                default: level_d = level_q;
            endcase
            if (capture_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // Next FIFO head; a capture landing in an empty slot bypasses the memory
    always_comb begin
        rsp_valid_d = 1'b0;
        rsp_p_d     = 48'd0;
        rsp_co_d    = 1'b0;
        if (level_d == 4'd0) begin
            rsp_valid_d = 1'b0;
        end else if (capture_s && (wr_ptr_q == rd_ptr_d)) begin
            rsp_valid_d = 1'b1;
            rsp_p_d     = dsp_p;
            rsp_co_d    = dsp_carryout;
        end else begin
            rsp_valid_d = 1'b1;
            rsp_p_d     = mem_p_q[rd_ptr_d];
            rsp_co_d    = mem_co_q[rd_ptr_d];
        end
    end

    // FSM state register and control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FLUSH;
            cnt_q       <= CNT_LOAD;
            dsp_rst_q   <= 1'b1;
            dsp_ce_q    <= 1'b1;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dsp_rst_q   <= dsp_rst_d;
            dsp_ce_q    <= dsp_ce_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    // Issue registers and valid pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsp_a_q       <= 18'd0;
            dsp_b_q       <= 18'd0;
            dsp_d_q       <= 18'd0;
            dsp_c_q       <= 48'd0;
            dsp_opmode_q  <= 8'h00;
            dsp_carryin_q <= 1'b0;
            last_opmode_q <= 8'h00;
            vpipe_q       <= '0;
        end else begin
            dsp_a_q       <= dsp_a_d;
            dsp_b_q       <= dsp_b_d;
            dsp_d_q       <= dsp_d_d;
            dsp_c_q       <= dsp_c_d;
            dsp_opmode_q  <= dsp_opmode_d;
            dsp_carryin_q <= dsp_carryin_d;
            last_opmode_q <= last_opmode_d;
            vpipe_q       <= vpipe_d;
        end
    end

    // Counters, FIFO storage and registered response head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q  <= 4'd0;
            level_q     <= 4'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_p_q     <= 48'd0;
            rsp_co_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_p_q[i]  <= 48'd0;
                mem_co_q[i] <= 1'b0;
            end
        end else begin
            inflight_q  <= inflight_d;
            level_q     <= level_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_p_q     <= rsp_p_d;
            rsp_co_q    <= rsp_co_d;
            if (capture_s) begin
                mem_p_q[wr_ptr_q]  <= dsp_p;
                mem_co_q[wr_ptr_q] <= dsp_carryout;
            end
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_p        = rsp_p_q;
    assign rsp_carryout = rsp_co_q;
    assign dsp_a        = dsp_a_q;
    assign dsp_b        = dsp_b_q;
    assign dsp_d        = dsp_d_q;
    assign dsp_c        = dsp_c_q;
    assign dsp_opmode   = dsp_opmode_q;
    assign dsp_carryin  = dsp_carryin_q;
    assign dsp_ce       = dsp_ce_q;
    assign dsp_rst      = dsp_rst_q;
    assign inflight     = inflight_q;
    assign fifo_level   = level_q;

endmodule
